// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control and execute unit: single-cycle ALU ops plus iterative MULT/MULTU/DIV/DIVU into HI/LO.
// Define ALU_MULDIV_DIVIDE_EN to build the divider; without it div/divu decode as illegal.
module alu_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             done,
    output logic             busy,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
    } op_t;

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t             state_q, state_d;
    op_t                op;
    logic               accept, is_long, is_signed, slt_s;
    logic [WIDTH-1:0]   alu_res, mag_a, mag_b;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, mcand_q;
    logic               neg_lo_q;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   iter_hi, iter_lo, fix_hi, fix_lo;
`ifdef ALU_MULDIV_DIVIDE_EN
    logic               div_q, div0_q, neg_hi_q, div_ok;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_sub;
`endif

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        op = OP_ILL;
        case (alu_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: op = OP_ADD;
                    6'b100010, 6'b100011: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b101011: op = OP_SLTU;
                    6'b010000: op = OP_MFHI;
                    6'b010010: op = OP_MFLO;
                    6'b011000: op = OP_MULT;
                    6'b011001: op = OP_MULTU;
`ifdef ALU_MULDIV_DIVIDE_EN
                    6'b011010: op = OP_DIV;
                    6'b011011: op = OP_DIVU;
`endif
                    default:   op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    always_comb begin
        slt_s   = $signed(a) < $signed(b);
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // Iterations run on magnitudes; signs are restored in the final RUN cycle.
    assign is_long   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
    assign accept    = valid && (state_q != RUN);

    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        iter_hi  = mul_sum[WIDTH:1];
        iter_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        prod_neg = -{acc_hi_q, acc_lo_q};
        {fix_hi, fix_lo} = neg_lo_q ? prod_neg : {acc_hi_q, acc_lo_q};
`ifdef ALU_MULDIV_DIVIDE_EN
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ok    = div_shift >= {1'b0, mcand_q};
        div_sub   = div_shift[WIDTH-1:0] - mcand_q;
        if (div_q) begin
            iter_hi = div_ok ? div_sub : div_shift[WIDTH-1:0];
            iter_lo = {acc_lo_q[WIDTH-2:0], div_ok};
            fix_lo  = div0_q ? '1 : (neg_lo_q ? -acc_lo_q : acc_lo_q);
            fix_hi  = neg_hi_q ? -acc_hi_q : acc_hi_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: if (valid && is_long) state_d = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE:    state_d = (valid && is_long) ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result   <= '0;
            zero     <= 1'b1;
            done     <= 1'b0;
            illegal  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            neg_lo_q <= 1'b0;
`ifdef ALU_MULDIV_DIVIDE_EN
            div_q    <= 1'b0;
            div0_q   <= 1'b0;
            neg_hi_q <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            // HI/LO commit at the end of DONE, so an MFHI/MFLO accepted in that cycle reads the old values.
            if (state_q == DONE) begin
                hi <= acc_hi_q;
                lo <= acc_lo_q;
            end
            if (accept) begin
                if (is_long) begin
                    acc_hi_q <= '0;
                    acc_lo_q <= mag_a;
                    mcand_q  <= mag_b;
                    neg_lo_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    cnt_q    <= '0;
`ifdef ALU_MULDIV_DIVIDE_EN
                    div_q    <= (op == OP_DIV) || (op == OP_DIVU);
                    div0_q   <= (b == '0);
                    neg_hi_q <= is_signed && a[WIDTH-1];
`endif
                end else begin
                    result  <= alu_res;
                    zero    <= (alu_res == '0);
                    done    <= 1'b1;
                    illegal <= (op == OP_ILL);
                end
            end else if (state_q == RUN) begin
                if (cnt_q == LAST) begin
                    acc_hi_q <= fix_hi;
                    acc_lo_q <= fix_lo;
                    result   <= '0;
                    zero     <= 1'b1;
                    done     <= 1'b1;
                end else begin
                    acc_hi_q <= iter_hi;
                    acc_lo_q <= iter_lo;
                    cnt_q    <= cnt_q + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Self-checking bench for alu_muldiv_ctrl (WIDTH=32); expectations follow ALU_MULDIV_DIVIDE_EN.
module tb_alu_muldiv_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, valid;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] a, b, result, hi, lo;
    logic         zero, done, busy, illegal;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         ill;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] exp_hi, exp_lo;

    always #5 clk = ~clk;

    alu_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .valid(valid), .alu_op(alu_op), .funct(funct),
        .a(a), .b(b), .result(result), .zero(zero), .done(done), .busy(busy),
        .illegal(illegal), .hi(hi), .lo(lo)
    );

    // Scoreboard monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: result=%h illegal=%b with no request outstanding", result, illegal);
            end else begin
                mon_e = sb.pop_front();
                if (result !== mon_e.res || illegal !== mon_e.ill || zero !== (mon_e.res == '0) || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s: result=%h zero=%b illegal=%b busy=%b, expected result=%h zero=%b illegal=%b busy=0",
                             mon_e.name, result, zero, illegal, busy, mon_e.res, (mon_e.res == '0), mon_e.ill);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push(input string n, input logic [W-1:0] r, input logic il);
        exp_t e;
        e.name = n;
        e.res  = r;
        e.ill  = il;
        sb.push_back(e);
    endfunction

    function automatic void model(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic il);
        il = 1'b0;
        r  = '0;
        if (op == 2'b00) r = x + y;
        else if (op == 2'b01) r = x - y;
        else if (op == 2'b11) il = 1'b1;
        else begin
            case (fn)
                6'h20, 6'h21: r = x + y;
                6'h22, 6'h23: r = x - y;
                6'h24: r = x & y;
                6'h25: r = x | y;
                6'h26: r = x ^ y;
                6'h27: r = ~(x | y);
                6'h2A: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                6'h2B: r = (x < y) ? 32'd1 : 32'd0;
                6'h10: r = exp_hi;
                6'h12: r = exp_lo;
                default: il = 1'b1;
            endcase
        end
    endfunction

    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
        alu_op = op;
        funct  = fn;
        a      = x;
        b      = y;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
    endtask

    task automatic issue_single(input string n, input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic         il;
        model(op, fn, x, y, r, il);
        push(n, r, il);
        issue(op, fn, x, y);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_latency: done=%b one cycle after accept, expected 1", n, done);
        end
    endtask

    task automatic wait_done(input int start, output int n);
        n = start;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; valid = 1'b0; alu_op = 2'b00; funct = 6'h00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (result !== '0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_result: result=%h zero=%b, expected 00000000 and 1", result, zero);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: done=%b busy=%b illegal=%b, expected all 0", done, busy, illegal);
        end
        checks++;
        if (hi !== '0 || lo !== '0) begin
            failures++;
            $display("FAIL reset_hilo: hi=%h lo=%h, expected 0", hi, lo);
        end
        exp_hi = '0;
        exp_lo = '0;
    endtask

    task automatic test_slt;
        issue_single("slt", 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        issue_single("sltu", 2'b10, 6'h2B, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
    endtask

    task automatic test_alu_ops;
        logic [5:0] fns[10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        logic [W-1:0] x, y;
        for (int i = 0; i < 12; i++) begin
            x = $urandom;
            y = (i % 3 == 0) ? x : $urandom;
            if (i < 10) issue_single($sformatf("alu_f%0h", fns[i]), 2'b10, fns[i], x, y);
            else        issue_single($sformatf("alu_op%0d", i - 10), 2'(i - 10), 6'($urandom), x, y);
            @(negedge clk);
        end
        issue_single("add_wrap", 2'b00, 6'h00, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        issue_single("b2b_add", 2'b10, 6'h20, 32'd100, 32'd23);
        issue_single("b2b_sub", 2'b10, 6'h22, 32'd5, 32'd9);
        issue_single("b2b_ill", 2'b10, 6'h3F, 32'd1, 32'd1);
        issue_single("b2b_nor", 2'b10, 6'h27, 32'h0F0F_0000, 32'h0000_00FF);
        issue_single("b2b_beq", 2'b01, 6'h00, 32'd77, 32'd77);
        @(negedge clk);
    endtask

    task automatic test_multu_busy;
        int n;
        push("multu_done", '0, 1'b0);
        issue(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL multu_busy: busy=%b done=%b after accept, expected 1 and 0", busy, done);
        end
        repeat (4) @(negedge clk);
        issue(2'b00, 6'h00, 32'd1, 32'd2);
        wait_done(6, n);
        checks++;
        if (n != 34) begin
            failures++;
            $display("FAIL multu_latency: done after %0d cycles, expected 34", n);
        end
        issue_single("add_in_done", 2'b00, 6'h00, 32'd2, 32'd3);
        exp_hi = 32'hFFFF_FFFE;
        exp_lo = 32'h0000_0001;
        checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            failures++;
            $display("FAIL multu_hilo: hi=%h lo=%h, expected %h %h", hi, lo, exp_hi, exp_lo);
        end
        @(negedge clk);
    endtask

    task automatic test_mult;
        int n;
        push("mult_done", '0, 1'b0);
        issue(2'b10, 6'h18, 32'hFFFF_FFFE, 32'd3);
        wait_done(1, n);
        checks++;
        if (n != 34) begin
            failures++;
            $display("FAIL mult_latency: done after %0d cycles, expected 34", n);
        end
        issue_single("mfhi_in_done", 2'b10, 6'h10, '0, '0);
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFFA;
        checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            failures++;
            $display("FAIL mult_hilo: hi=%h lo=%h, expected %h %h", hi, lo, exp_hi, exp_lo);
        end
        issue_single("mflo_after", 2'b10, 6'h12, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_div;
        logic [5:0]   fns[5] = '{6'h1A, 6'h1B, 6'h1A, 6'h1A, 6'h1B};
        logic [W-1:0] xs[5]  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF};
        logic [W-1:0] ys[5]  = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd10};
`ifdef ALU_MULDIV_DIVIDE_EN
        logic [W-1:0] qs[5]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF2, 32'h1999_9999};
        logic [W-1:0] rs[5]  = '{32'hFFFF_FFFF, 32'd7, 32'd0, 32'd2, 32'd5};
        int n;
        for (int i = 0; i < 5; i++) begin
            push($sformatf("div%0d_done", i), '0, 1'b0);
            issue(2'b10, fns[i], xs[i], ys[i]);
            wait_done(1, n);
            checks++;
            if (n != 34) begin
                failures++;
                $display("FAIL div%0d_latency: done after %0d cycles, expected 34", i, n);
            end
            @(negedge clk);
            exp_hi = rs[i];
            exp_lo = qs[i];
            checks++;
            if (hi !== exp_hi || lo !== exp_lo) begin
                failures++;
                $display("FAIL div%0d_hilo: hi=%h lo=%h, expected %h %h", i, hi, lo, exp_hi, exp_lo);
            end
        end
`else
        for (int i = 0; i < 5; i++) begin
            push($sformatf("div%0d_illegal", i), '0, 1'b1);
            issue(2'b10, fns[i], xs[i], ys[i]);
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
                failures++;
                $display("FAIL div%0d_disabled: done=%b busy=%b hi=%h lo=%h, expected 1 0 %h %h", i, done, busy, hi, lo, exp_hi, exp_lo);
            end
            @(negedge clk);
        end
`endif
    endtask

    task automatic test_illegal;
        issue_single("pre_ill_add", 2'b00, 6'h00, 32'd7, 32'd8);
        issue_single("alu_op11", 2'b11, 6'h20, 32'd3, 32'd4);
        issue_single("funct3f", 2'b10, 6'h3F, 32'd3, 32'd4);
        checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            failures++;
            $display("FAIL illegal_hilo: hi=%h lo=%h, expected unchanged %h %h", hi, lo, exp_hi, exp_lo);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int seen;
        issue(2'b10, 6'h18, 32'd5, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            failures++;
            $display("FAIL abort_state: busy=%b done=%b hi=%h lo=%h, expected 0 0 0 0", busy, done, hi, lo);
        end
        reset  = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        seen   = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_done: %0d done pulses after abort, expected 0", seen);
        end
        issue_single("add_after_abort", 2'b00, 6'h00, 32'd5, 32'd6);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_slt();
        test_alu_ops();
        test_back_to_back();
        test_multu_busy();
        test_mult();
        test_div();
        test_illegal();
        test_abort();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d requests never completed, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
